// File: rtl/dot_prod_sequencer.sv
// Purpose : sequences operand reads for one matrix-vector command and drives the reduction
//           unit's clear/enable/shift so each row's chunk results land in its own dot_out lane.
// Latency : first read 1 cycle after accept; done 1 cycle after the final dot_prod_en
//           (unstalled: accept T, done T + rows*chunks + PE_LAT + 1).
// Backpressure: cmd_ready low while a command is in flight; rd_stall holds the read sequence,
//           and stalled cycles travel down the delay line as bubbles.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake; cmd_ready is high only in IDLE
//   cmd_rows, cmd_chunks      rows R (0..PE_COUNT) and chunks per row C
//   cmd_mat_base/vec_base     operand base addresses in chunk units
//   rd_stall                  operand fetch refuses a read this cycle
//   rd_en, mat_addr, vec_addr operand read request
//   dp_clr                    one-cycle clear of the reduction unit, cycle after accept
//   dot_prod_en, shift        reduction enable / lane advance, aligned with pe_res
//   busy, done                command in flight / one-cycle completion pulse
module dot_prod_sequencer #(
    parameter int PE_COUNT = 4,
    parameter int ADDR_W   = 16,
    parameter int CHUNK_W  = 8,
    parameter int PE_LAT   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [$clog2(PE_COUNT+1)-1:0] cmd_rows,
    input  logic [CHUNK_W-1:0]            cmd_chunks,
    input  logic [ADDR_W-1:0]             cmd_mat_base,
    input  logic [ADDR_W-1:0]             cmd_vec_base,
    input  logic                          rd_stall,
    output logic                          rd_en,
    output logic [ADDR_W-1:0]             mat_addr,
    output logic [ADDR_W-1:0]             vec_addr,
    output logic                          dp_clr,
    output logic                          dot_prod_en,
    output logic                          shift,
    output logic                          busy,
    output logic                          done
);

    localparam int ROW_W = $clog2(PE_COUNT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // All delay-line stages except the output stage. When none of them holds an
    // enable during DRAIN, the final enable is at (or past) the output stage.
    localparam logic [PE_LAT-1:0] EARLY_MASK = {PE_LAT{1'b1}} >> 1;

    logic [1:0]         state;
    logic [1:0]         state_nxt;

    logic [ROW_W-1:0]   rows_q;
    logic [CHUNK_W-1:0] chunks_q;
    logic [ADDR_W-1:0]  vec_base_q;
    logic [ROW_W-1:0]   row_idx;
    logic [CHUNK_W-1:0] chunk_idx;

    logic [PE_LAT-1:0]  pipe_en;
    logic [PE_LAT-1:0]  pipe_first;

    logic               accept;
    logic               zero_cmd;
    logic               last_chunk;
    logic               last_row;
    logic               early_busy;

    // ------------------------------------------------------------------
    // Handshake and status decode
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready   = (state == S_IDLE);
        accept      = cmd_valid && cmd_ready;
        zero_cmd    = (cmd_rows == '0) || (cmd_chunks == '0);
        rd_en       = (state == S_ISSUE) && !rd_stall;
        last_chunk  = (chunk_idx == chunks_q - CHUNK_W'(1));
        last_row    = (row_idx == rows_q - ROW_W'(1));
        early_busy  = |(pipe_en & EARLY_MASK);
        busy        = (state == S_ISSUE) || (state == S_DRAIN);
        done        = (state == S_DONE);
        dot_prod_en = pipe_en[PE_LAT-1];
        // pipe_first is only ever set together with pipe_en, so shift is
        // automatically low on bubbles.
        shift       = pipe_first[PE_LAT-1];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // An empty command still passes through DRAIN for one cycle: the
                // delay line is already empty, so done follows dp_clr by one
                // cycle exactly like the tail of a real command.
                if (accept) begin
                    state_nxt = zero_cmd ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rd_en && last_chunk && last_row) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!early_busy) begin
                    state_nxt = S_DONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control state, command latch and read address generation
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rows_q     <= '0;
            chunks_q   <= '0;
            vec_base_q <= '0;
            row_idx    <= '0;
            chunk_idx  <= '0;
            mat_addr   <= '0;
            vec_addr   <= '0;
            dp_clr     <= 1'b0;
        end else begin
            state  <= state_nxt;
            dp_clr <= accept;

            if (accept) begin
                rows_q     <= cmd_rows;
                chunks_q   <= cmd_chunks;
                vec_base_q <= cmd_vec_base;
                row_idx    <= '0;
                chunk_idx  <= '0;
                mat_addr   <= cmd_mat_base;
                vec_addr   <= cmd_vec_base;
            end else if (rd_en) begin
                // Row-major matrix storage makes (r*C + c) contiguous, so the
                // matrix address simply increments on every read, row wrap or not.
                mat_addr <= mat_addr + ADDR_W'(1);
                if (last_chunk) begin
                    chunk_idx <= '0;
                    row_idx   <= row_idx + ROW_W'(1);
                    vec_addr  <= vec_base_q;
                end else begin
                    chunk_idx <= chunk_idx + CHUNK_W'(1);
                    vec_addr  <= vec_addr + ADDR_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // PE latency delay line: shifts every cycle, stalls become bubbles
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_en    <= '0;
            pipe_first <= '0;
        end else begin
            pipe_en[0]    <= rd_en;
            pipe_first[0] <= rd_en && (chunk_idx == '0);
            for (int i = 1; i < PE_LAT; i++) begin
                pipe_en[i]    <= pipe_en[i-1];
                pipe_first[i] <= pipe_first[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sanity properties
    // ------------------------------------------------------------------
    // One dot_out lane per row: more rows than lanes would overrun the unit.
    assert property (@(posedge clk) disable iff (rst)
        accept |-> (cmd_rows <= ROW_W'(PE_COUNT)));

    // done marks the end of busy; the two never overlap.
    assert property (@(posedge clk) disable iff (rst)
        done |-> !busy);

    // No reduction enable may still be in flight once done is signalled.
    assert property (@(posedge clk) disable iff (rst)
        done |-> (pipe_en == '0));

endmodule

// File: tb/tb_dot_prod_sequencer.sv
// Purpose : directed, table-driven check of dot_prod_sequencer (PE_LAT = 2).
// Latency : each table entry runs from accept to its done pulse, entries back to back.
// Backpressure: rd_stall patterns per entry; cmd_valid held with junk while busy.
module tb_dot_prod_sequencer;

    localparam int PE_COUNT = 4;
    localparam int ADDR_W   = 16;
    localparam int CHUNK_W  = 8;
    localparam int PE_LAT   = 2;
    localparam int ROW_W    = $clog2(PE_COUNT + 1);
    localparam int NTBL     = 7;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ROW_W-1:0]  cmd_rows;
    logic [CHUNK_W-1:0] cmd_chunks;
    logic [ADDR_W-1:0] cmd_mat_base;
    logic [ADDR_W-1:0] cmd_vec_base;
    logic              rd_stall;
    logic              rd_en;
    logic [ADDR_W-1:0] mat_addr;
    logic [ADDR_W-1:0] vec_addr;
    logic              dp_clr;
    logic              dot_prod_en;
    logic              shift;
    logic              busy;
    logic              done;

    dot_prod_sequencer #(
        .PE_COUNT (PE_COUNT),
        .ADDR_W   (ADDR_W),
        .CHUNK_W  (CHUNK_W),
        .PE_LAT   (PE_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rows     (cmd_rows),
        .cmd_chunks   (cmd_chunks),
        .cmd_mat_base (cmd_mat_base),
        .cmd_vec_base (cmd_vec_base),
        .rd_stall     (rd_stall),
        .rd_en        (rd_en),
        .mat_addr     (mat_addr),
        .vec_addr     (vec_addr),
        .dp_clr       (dp_clr),
        .dot_prod_en  (dot_prod_en),
        .shift        (shift),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One command plus the hand-computed cycle (relative to accept) of done and
    // the number of reads it must issue.
    typedef struct {
        int          rows;
        int          chunks;
        int          mat_base;
        int          vec_base;
        logic [31:0] stall;      // bit k: rd_stall during cycle T+k
        int          exp_done;
        int          exp_reads;
    } vec_t;

    vec_t tbl [NTBL];
    int   n_vec;
    int   n_miss;

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s at T+%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input vec_t v);
        int exp_rd    [64];
        int exp_first [64];
        int exp_mat   [64];
        int exp_vec   [64];
        int chk_addr  [64];
        int issued;
        int total;
        int last_k;
        int done_k;
        int act_done;
        int reads;
        int exp_de;

        // Expected trace: read n of the command is row n/C, chunk n%C.
        issued = 0;
        total  = v.rows * v.chunks;
        last_k = 0;
        for (int k = 0; k < 64; k++) begin
            exp_rd[k]    = 0;
            exp_first[k] = 0;
            exp_mat[k]   = 0;
            exp_vec[k]   = 0;
            chk_addr[k]  = 0;
            if (k >= 1 && issued < total) begin
                chk_addr[k] = 1;
                exp_mat[k]  = (v.mat_base + (issued / v.chunks) * v.chunks + (issued % v.chunks)) & 'hFFFF;
                exp_vec[k]  = (v.vec_base + (issued % v.chunks)) & 'hFFFF;
                if (!(k < 32 && v.stall[k])) begin
                    exp_rd[k]    = 1;
                    exp_first[k] = (issued % v.chunks == 0) ? 1 : 0;
                    issued++;
                    last_k = k;
                end
            end
        end
        done_k = (total == 0) ? 2 : last_k + PE_LAT + 1;
        if (done_k > 60) done_k = 60;

        // Cycle T: offer the command.
        step();
        cmd_valid    = 1'b1;
        cmd_rows     = ROW_W'(v.rows);
        cmd_chunks   = CHUNK_W'(v.chunks);
        cmd_mat_base = ADDR_W'(v.mat_base);
        cmd_vec_base = ADDR_W'(v.vec_base);
        rd_stall     = v.stall[0];
        #1;
        chk("cmd_ready_at_accept", 0, int'(cmd_ready), 1);

        act_done = -1;
        reads    = 0;
        for (int k = 1; k <= done_k; k++) begin
            step();
            // A competing command held on the bus while busy must be ignored.
            cmd_valid    = 1'b1;
            cmd_rows     = ROW_W'(PE_COUNT);
            cmd_chunks   = 8'hFF;
            cmd_mat_base = 16'hAAAA;
            cmd_vec_base = 16'h5555;
            rd_stall     = (k < 32) ? v.stall[k] : 1'b0;
            #1;
            exp_de = (k > PE_LAT) ? exp_rd[k-PE_LAT] : 0;
            chk("rd_en", k, int'(rd_en), exp_rd[k]);
            if (chk_addr[k] != 0) begin
                chk("mat_addr", k, int'(mat_addr), exp_mat[k]);
                chk("vec_addr", k, int'(vec_addr), exp_vec[k]);
            end
            chk("dp_clr", k, int'(dp_clr), (k == 1) ? 1 : 0);
            chk("dot_prod_en", k, int'(dot_prod_en), exp_de);
            chk("shift", k, int'(shift), (k > PE_LAT) ? exp_first[k-PE_LAT] : 0);
            chk("busy", k, int'(busy), (k < done_k) ? 1 : 0);
            chk("cmd_ready", k, int'(cmd_ready), 0);
            if (rd_en) reads++;
            if (done && act_done < 0) act_done = k;
        end
        cmd_valid = 1'b0;
        rd_stall  = 1'b0;
        chk("done_cycle", 0, act_done, v.exp_done);
        chk("read_count", 0, reads, v.exp_reads);
    endtask

    initial begin
        //         rows chunks mat      vec      stall       done reads
        tbl[0] = '{4,   2,     'h0010,  'h0040,  32'h0,      11,  8};   // basic
        tbl[1] = '{4,   2,     'h0010,  'h0040,  32'h18,     13,  8};   // stall T+3,T+4
        tbl[2] = '{1,   1,     'h0100,  'h0200,  32'h0,      4,   1};   // single chunk
        tbl[3] = '{0,   5,     'h0300,  'h0400,  32'h0,      2,   0};   // zero rows
        tbl[4] = '{3,   0,     'h0300,  'h0400,  32'h0,      2,   0};   // zero chunks
        tbl[5] = '{2,   2,     'hFFFE,  'hFFFF,  32'h0,      7,   4};   // address wrap
        tbl[6] = '{2,   3,     'h0020,  'h0080,  32'h642,    11,  6};   // first-cycle stall, drain stalls

        n_vec        = 0;
        n_miss       = 0;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_rows     = '0;
        cmd_chunks   = '0;
        cmd_mat_base = '0;
        cmd_vec_base = '0;
        rd_stall     = 1'b0;

        // Reset state.
        step();
        step();
        #1;
        chk("rst_rd_en",       0, int'(rd_en), 0);
        chk("rst_dp_clr",      0, int'(dp_clr), 0);
        chk("rst_dot_prod_en", 0, int'(dot_prod_en), 0);
        chk("rst_shift",       0, int'(shift), 0);
        chk("rst_busy",        0, int'(busy), 0);
        chk("rst_done",        0, int'(done), 0);
        chk("rst_mat_addr",    0, int'(mat_addr), 0);
        chk("rst_vec_addr",    0, int'(vec_addr), 0);
        chk("rst_cmd_ready",   0, int'(cmd_ready), 1);
        step();
        rst = 1'b0;
        step();
        #1;
        chk("post_rst_dp_clr", 0, int'(dp_clr), 0);
        chk("post_rst_busy",   0, int'(busy), 0);

        // Table entries, each accepted in the cycle after the previous done.
        for (int i = 0; i < NTBL; i++) begin
            run_cmd(tbl[i]);
        end

        // Reset in the middle of a command.
        step();
        cmd_valid    = 1'b1;
        cmd_rows     = 3'd4;
        cmd_chunks   = 8'd2;
        cmd_mat_base = 16'h0010;
        cmd_vec_base = 16'h0040;
        #1;
        chk("mid_rst_accept", 0, int'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
        #1;
        chk("mid_rst_rd_en_1",  1, int'(rd_en), 1);
        chk("mid_rst_dp_clr_1", 1, int'(dp_clr), 1);
        step();
        #1;
        chk("mid_rst_mat_2", 2, int'(mat_addr), 'h11);
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_en_3",    3, int'(dot_prod_en), 1);
        chk("mid_rst_shift_3", 3, int'(shift), 1);
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_rd_en",       4, int'(rd_en), 0);
        chk("mid_rst_dot_prod_en", 4, int'(dot_prod_en), 0);
        chk("mid_rst_shift",       4, int'(shift), 0);
        chk("mid_rst_busy",        4, int'(busy), 0);
        chk("mid_rst_done",        4, int'(done), 0);
        chk("mid_rst_dp_clr",      4, int'(dp_clr), 0);
        chk("mid_rst_mat_addr",    4, int'(mat_addr), 0);
        chk("mid_rst_vec_addr",    4, int'(vec_addr), 0);
        chk("mid_rst_cmd_ready",   4, int'(cmd_ready), 1);
        for (int k = 5; k <= 10; k++) begin
            step();
            #1;
            chk("mid_rst_no_done", k, int'(done), 0);
            chk("mid_rst_no_en",   k, int'(dot_prod_en), 0);
        end

        // A clean command after the aborted one.
        run_cmd(tbl[2]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
